// File: rtl/arm_cpu_core.sv
// Single-cycle 64-bit LEGv8 subset core: PC, decode, 32x64 register file, ALU, NZVC flags.
// Optional CPU_FLAGS_OUT_EN exposes the flag register as flags[3:0] = {N,Z,C,V}.
module arm_cpu_core #(
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic [63:0] dmem_addr,
  output logic [63:0] dmem_wdata,
  output logic        dmem_we,
  output logic        dmem_re,
  input  logic [63:0] dmem_rdata
`ifdef CPU_FLAGS_OUT_EN
  ,
  output logic [3:0]  flags
`endif
);

  typedef enum logic [3:0] {
    I_NOP, I_ADDI, I_ADDS, I_SUBS, I_LDUR, I_STUR,
    I_B, I_BL, I_BR, I_CBZ, I_BLT
  } iclass_t;

  typedef enum logic [2:0] {
    ALU_PASS = 3'b000,
    ALU_ADD  = 3'b010,
    ALU_SUB  = 3'b011,
    ALU_AND  = 3'b100,
    ALU_ORR  = 3'b101,
    ALU_EOR  = 3'b110
  } alu_op_t;

  typedef enum logic [1:0] {B_REG, B_IMM12, B_IMM9} bsel_t;
  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_LINK} wsel_t;

  logic [63:0] pc;
  logic [63:0] regs [32];
  logic [3:0]  nzcv;

  logic [4:0]  rd_idx, rn_idx, rm_idx, rb_idx;
  iclass_t     iclass;

  logic        reg_we, flags_we, mem_we, mem_re, rb_from_rt;
  bsel_t       b_sel;
  wsel_t       w_sel;
  alu_op_t     alu_op;

  logic [63:0] rd1, rd2, alu_a, alu_b, b_eff, alu_res;
  logic [64:0] sum;
  logic        alu_n, alu_z, alu_c, alu_v;
  logic [63:0] imm12_z, imm9_s, off19, off26;
  logic [63:0] pc_plus4, br_target19, br_target26, next_pc;
  logic [4:0]  wr_idx;
  logic [63:0] wr_data;

  assign rd_idx = imem_instr[4:0];
  assign rn_idx = imem_instr[9:5];
  assign rm_idx = imem_instr[20:16];

  // Instruction classification on the opcode field; anything unmatched is a NOP.
  always_comb begin
    iclass = I_NOP;
    if (imem_instr[31:22] == 10'b1001000100)        iclass = I_ADDI;
    else if (imem_instr[31:21] == 11'b10101011000)  iclass = I_ADDS;
    else if (imem_instr[31:21] == 11'b11101011000)  iclass = I_SUBS;
    else if (imem_instr[31:21] == 11'b11111000010)  iclass = I_LDUR;
    else if (imem_instr[31:21] == 11'b11111000000)  iclass = I_STUR;
    else if (imem_instr[31:26] == 6'b000101)        iclass = I_B;
    else if (imem_instr[31:26] == 6'b100101)        iclass = I_BL;
    else if (imem_instr[31:21] == 11'b11010110000)  iclass = I_BR;
    else if (imem_instr[31:24] == 8'b10110100)      iclass = I_CBZ;
    else if (imem_instr[31:24] == 8'b01010100 && imem_instr[4:0] == 5'b01011)
      iclass = I_BLT;
  end

  always_comb begin
    reg_we     = 1'b0;
    flags_we   = 1'b0;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    rb_from_rt = 1'b0;
    b_sel      = B_REG;
    w_sel      = WB_ALU;
    alu_op     = ALU_PASS;
    case (iclass)
      I_ADDI: begin
        reg_we = 1'b1;
        b_sel  = B_IMM12;
        alu_op = ALU_ADD;
      end
      I_ADDS: begin
        reg_we   = 1'b1;
        flags_we = 1'b1;
        alu_op   = ALU_ADD;
      end
      I_SUBS: begin
        reg_we   = 1'b1;
        flags_we = 1'b1;
        alu_op   = ALU_SUB;
      end
      I_LDUR: begin
        reg_we = 1'b1;
        mem_re = 1'b1;
        b_sel  = B_IMM9;
        w_sel  = WB_MEM;
        alu_op = ALU_ADD;
      end
      I_STUR: begin
        mem_we     = 1'b1;
        rb_from_rt = 1'b1;
        b_sel      = B_IMM9;
        alu_op     = ALU_ADD;
      end
      I_BL: begin
        reg_we = 1'b1;
        w_sel  = WB_LINK;
      end
      I_BR:  rb_from_rt = 1'b1;
      // CBZ tests Rt through the ALU's pass-B path and its zero detect.
      I_CBZ: rb_from_rt = 1'b1;
      default: ;
    endcase
  end

  assign rb_idx = rb_from_rt ? rd_idx : rm_idx;
  assign rd1    = (rn_idx == 5'd31) ? 64'd0 : regs[rn_idx];
  assign rd2    = (rb_idx == 5'd31) ? 64'd0 : regs[rb_idx];

  assign imm12_z = {52'd0, imem_instr[21:10]};
  assign imm9_s  = {{55{imem_instr[20]}}, imem_instr[20:12]};
  assign off19   = {{43{imem_instr[23]}}, imem_instr[23:5], 2'b00};
  assign off26   = {{36{imem_instr[25]}}, imem_instr[25:0], 2'b00};

  always_comb begin
    alu_b = rd2;
    case (b_sel)
      B_IMM12: alu_b = imm12_z;
      B_IMM9:  alu_b = imm9_s;
      default: alu_b = rd2;
    endcase
  end

  assign alu_a = rd1;
  // Subtraction is Rn + ~Rm + 1, so the carry out means "no borrow".
  assign b_eff = (alu_op == ALU_SUB) ? ~alu_b : alu_b;
  assign sum   = {1'b0, alu_a} + {1'b0, b_eff} + {64'd0, (alu_op == ALU_SUB)};

  always_comb begin
    alu_res = alu_b;
    case (alu_op)
      ALU_ADD, ALU_SUB: alu_res = sum[63:0];
      ALU_AND:          alu_res = alu_a & alu_b;
      ALU_ORR:          alu_res = alu_a | alu_b;
      ALU_EOR:          alu_res = alu_a ^ alu_b;
      default:          alu_res = alu_b;
    endcase
  end

  assign alu_n = alu_res[63];
  assign alu_z = (alu_res == 64'd0);
  assign alu_c = sum[64];
  assign alu_v = (alu_a[63] == b_eff[63]) && (sum[63] != alu_a[63]);

  assign pc_plus4    = pc + 64'd4;
  assign br_target19 = pc + off19;
  assign br_target26 = pc + off26;

  // B.LT reads the flag register before this edge's update.
  always_comb begin
    next_pc = pc_plus4;
    case (iclass)
      I_B, I_BL: next_pc = br_target26;
      I_BR:      next_pc = rd2;
      I_CBZ:     next_pc = alu_z ? br_target19 : pc_plus4;
      I_BLT:     next_pc = (nzcv[3] ^ nzcv[0]) ? br_target19 : pc_plus4;
      default:   next_pc = pc_plus4;
    endcase
  end

  assign wr_idx = (w_sel == WB_LINK) ? 5'd30 : rd_idx;

  always_comb begin
    wr_data = alu_res;
    case (w_sel)
      WB_MEM:  wr_data = dmem_rdata;
      WB_LINK: wr_data = pc_plus4;
      default: wr_data = alu_res;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc   <= RESET_PC;
      nzcv <= 4'b0000;
      for (int i = 0; i < 32; i++) regs[i] <= 64'd0;
    end else begin
      pc <= next_pc;
      if (flags_we) nzcv <= {alu_n, alu_z, alu_c, alu_v};
      if (reg_we && wr_idx != 5'd31) regs[wr_idx] <= wr_data;
    end
  end

  assign imem_addr  = pc;
  assign dmem_addr  = alu_res;
  assign dmem_wdata = rd2;
  assign dmem_we    = mem_we & reset;
  assign dmem_re    = mem_re & reset;

`ifdef CPU_FLAGS_OUT_EN
  assign flags = nzcv;
`endif

endmodule

// File: tb/tb_arm_cpu_core.sv
// Bench for arm_cpu_core: directed vector table plus randomized instructions against an ISA-level model.
// Flag port checks compile in when CPU_FLAGS_OUT_EN is defined.
module tb_arm_cpu_core;

  logic        clk;
  logic        reset;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic [63:0] dmem_addr;
  logic [63:0] dmem_wdata;
  logic        dmem_we;
  logic        dmem_re;
  logic [63:0] dmem_rdata;
`ifdef CPU_FLAGS_OUT_EN
  logic [3:0]  flags;
`endif

  arm_cpu_core dut (
    .clk        (clk),
    .reset      (reset),
    .imem_addr  (imem_addr),
    .imem_instr (imem_instr),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_we    (dmem_we),
    .dmem_re    (dmem_re),
    .dmem_rdata (dmem_rdata)
`ifdef CPU_FLAGS_OUT_EN
    ,
    .flags      (flags)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- encoders ----------------
  function automatic logic [31:0] enc_addi(input int rd, input int rn, input int imm);
    return {10'b1001000100, 12'(imm), 5'(rn), 5'(rd)};
  endfunction
  function automatic logic [31:0] enc_adds(input int rd, input int rn, input int rm);
    return {11'b10101011000, 5'(rm), 6'd0, 5'(rn), 5'(rd)};
  endfunction
  function automatic logic [31:0] enc_subs(input int rd, input int rn, input int rm);
    return {11'b11101011000, 5'(rm), 6'd0, 5'(rn), 5'(rd)};
  endfunction
  function automatic logic [31:0] enc_ldur(input int rt, input int rn, input int imm);
    return {11'b11111000010, 9'(imm), 2'b00, 5'(rn), 5'(rt)};
  endfunction
  function automatic logic [31:0] enc_stur(input int rt, input int rn, input int imm);
    return {11'b11111000000, 9'(imm), 2'b00, 5'(rn), 5'(rt)};
  endfunction
  function automatic logic [31:0] enc_b(input int imm);
    return {6'b000101, 26'(imm)};
  endfunction
  function automatic logic [31:0] enc_bl(input int imm);
    return {6'b100101, 26'(imm)};
  endfunction
  function automatic logic [31:0] enc_br(input int rd);
    return {11'b11010110000, 5'b11111, 6'd0, 5'd0, 5'(rd)};
  endfunction
  function automatic logic [31:0] enc_cbz(input int rt, input int imm);
    return {8'b10110100, 19'(imm), 5'(rt)};
  endfunction
  function automatic logic [31:0] enc_blt(input int imm);
    return {8'b01010100, 19'(imm), 5'b01011};
  endfunction

  // ---------------- reference model ----------------
  logic [63:0] m_regs [32];
  logic [63:0] m_pc;
  logic        m_n, m_z, m_c, m_v;
  logic [63:0] m_mem [logic [63:0]];

  function automatic logic [63:0] rx(input logic [4:0] idx);
    return (idx == 5'd31) ? 64'd0 : m_regs[idx];
  endfunction

  function automatic logic [63:0] mem_rd(input logic [63:0] a);
    if (m_mem.exists(a)) return m_mem[a];
    return (a * 64'h9E37_79B9_7F4A_7C15) ^ 64'h0123_4567_89AB_CDEF;
  endfunction

  task automatic wx(input logic [4:0] idx, input logic [63:0] val);
    if (idx != 5'd31) m_regs[idx] = val;
  endtask

  task automatic model_reset();
    m_pc = 64'd0;
    for (int i = 0; i < 32; i++) m_regs[i] = 64'd0;
    {m_n, m_z, m_c, m_v} = 4'b0000;
  endtask

  task automatic model_step(input logic [31:0] ins, output logic e_we, output logic e_re,
                            output logic e_chk, output logic [63:0] e_addr,
                            output logic [63:0] e_wdata, output logic [63:0] e_rdata);
    logic [63:0] a, b, res, nxt, sx9, br19, br26;
    logic signed [63:0] sa, sb, sr;
    logic [4:0] rd, rn, rm;
    rd = ins[4:0];
    rn = ins[9:5];
    rm = ins[20:16];
    a  = rx(rn);
    e_we = 1'b0; e_re = 1'b0; e_chk = 1'b0;
    e_addr = '0; e_wdata = '0; e_rdata = '0;
    nxt  = m_pc + 64'd4;
    sx9  = 64'($signed(ins[20:12]));
    br19 = 64'($signed(ins[23:5])) * 64'd4;
    br26 = 64'($signed(ins[25:0])) * 64'd4;
    if (ins[31:22] == 10'b1001000100) begin
      res = a + 64'(ins[21:10]);
      wx(rd, res);
      e_chk = 1'b1; e_addr = res;
    end else if (ins[31:21] == 11'b10101011000 || ins[31:21] == 11'b11101011000) begin
      b = rx(rm);
      sa = a; sb = b;
      if (ins[30]) begin
        res = a - b;
        sr = res;
        m_c = (a >= b);
        m_v = (sb > 0 && sr > sa) || (sb < 0 && sr < sa);
      end else begin
        res = a + b;
        sr = res;
        m_c = (res < a);
        m_v = (sb > 0 && sr < sa) || (sb < 0 && sr > sa);
      end
      m_n = res[63];
      m_z = (res == 64'd0);
      wx(rd, res);
      e_chk = 1'b1; e_addr = res;
    end else if (ins[31:21] == 11'b11111000010) begin
      e_addr = a + sx9; e_chk = 1'b1; e_re = 1'b1;
      e_rdata = mem_rd(e_addr);
      wx(rd, e_rdata);
    end else if (ins[31:21] == 11'b11111000000) begin
      e_addr = a + sx9; e_chk = 1'b1; e_we = 1'b1;
      e_wdata = rx(rd);
      m_mem[e_addr] = e_wdata;
    end else if (ins[31:26] == 6'b000101) begin
      nxt = m_pc + br26;
    end else if (ins[31:26] == 6'b100101) begin
      wx(5'd30, m_pc + 64'd4);
      nxt = m_pc + br26;
    end else if (ins[31:21] == 11'b11010110000) begin
      nxt = rx(rd);
    end else if (ins[31:24] == 8'b10110100) begin
      e_chk = 1'b1; e_addr = rx(rd);
      if (rx(rd) == 64'd0) nxt = m_pc + br19;
    end else if (ins[31:24] == 8'b01010100 && rd == 5'b01011) begin
      if (m_n != m_v) nxt = m_pc + br19;
    end
    m_pc = nxt;
  endtask

  // One randomized/model-checked instruction, driven after a falling edge.
  task automatic mstep(input logic [31:0] ins);
    logic e_we, e_re, e_chk;
    logic [63:0] e_addr, e_wdata, e_rdata;
    chk("pc", imem_addr, m_pc);
    model_step(ins, e_we, e_re, e_chk, e_addr, e_wdata, e_rdata);
    imem_instr = ins;
    dmem_rdata = e_re ? e_rdata : {$urandom(), $urandom()};
    #1;
    chk("dmem_we", 64'(dmem_we), 64'(e_we));
    chk("dmem_re", 64'(dmem_re), 64'(e_re));
    if (e_chk) chk("dmem_addr", dmem_addr, e_addr);
    if (e_we) chk("dmem_wdata", dmem_wdata, e_wdata);
    @(posedge clk);
    #1;
`ifdef CPU_FLAGS_OUT_EN
    chk("flags", 64'(flags), 64'({m_n, m_z, m_c, m_v}));
`endif
    @(negedge clk);
  endtask

  function automatic int rand_imm9();
    case ($urandom_range(0, 4))
      0: return 0;
      1: return 8;
      2: return 16;
      3: return -8;
      default: return int'($urandom_range(0, 511));
    endcase
  endfunction

  function automatic int rand_base();
    return ($urandom_range(0, 1) == 1) ? 31 : int'($urandom_range(0, 31));
  endfunction

  function automatic logic [31:0] rand_instr();
    int rd, rn, rm;
    rd = int'($urandom_range(0, 31));
    rn = int'($urandom_range(0, 31));
    rm = int'($urandom_range(0, 31));
    case ($urandom_range(0, 12))
      0, 1: return enc_addi(rd, rn, int'($urandom_range(0, 4095)));
      2:    return enc_adds(rd, rn, rm);
      3, 4: return enc_subs(rd, rn, rm);
      5:    return enc_ldur(rd, rand_base(), rand_imm9());
      6:    return enc_stur(rd, rand_base(), rand_imm9());
      7:    return enc_b(int'($urandom()));
      8:    return enc_bl(int'($urandom_range(0, 2000)) - 1000);
      9:    return enc_br(rd);
      10:   return enc_cbz(($urandom_range(0, 2) == 0) ? 31 : rd, int'($urandom()));
      11:   return enc_blt(int'($urandom()));
      default: return $urandom();
    endcase
  endfunction

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [31:0] instr;
    logic [63:0] rdata;
    logic [63:0] pc;
    logic        we;
    logic        re;
    logic        chk_addr;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [3:0]  nzcv;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  initial begin
    logic e_we, e_re, e_chk;
    logic [63:0] e_addr, e_wdata, e_rdata;

    vecs[0]  = '{enc_addi(0, 31, 5),  64'd0, 64'h00, 1'b0, 1'b0, 1'b1, 64'd5, 64'd0, 4'b0000};
    vecs[1]  = '{enc_addi(1, 31, 3),  64'd0, 64'h04, 1'b0, 1'b0, 1'b1, 64'd3, 64'd0, 4'b0000};
    vecs[2]  = '{enc_subs(2, 0, 1),   64'd0, 64'h08, 1'b0, 1'b0, 1'b1, 64'd2, 64'd0, 4'b0010};
    vecs[3]  = '{enc_subs(3, 1, 0),   64'd0, 64'h0C, 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0, 4'b1000};
    vecs[4]  = '{enc_blt(2),          64'd0, 64'h10, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 4'b1000};
    vecs[5]  = '{enc_stur(0, 31, 8),  64'd0, 64'h18, 1'b1, 1'b0, 1'b1, 64'd8, 64'd5, 4'b1000};
    vecs[6]  = '{enc_ldur(4, 31, 8),  64'd5, 64'h1C, 1'b0, 1'b1, 1'b1, 64'd8, 64'd0, 4'b1000};
    vecs[7]  = '{enc_cbz(31, -1),     64'd0, 64'h20, 1'b0, 1'b0, 1'b1, 64'd0, 64'd0, 4'b1000};
    vecs[8]  = '{enc_cbz(0, -1),      64'd0, 64'h1C, 1'b0, 1'b0, 1'b1, 64'd5, 64'd0, 4'b1000};
    vecs[9]  = '{enc_addi(5, 4, 0),   64'd0, 64'h20, 1'b0, 1'b0, 1'b1, 64'd5, 64'd0, 4'b1000};
    vecs[10] = '{enc_b(7),            64'd0, 64'h24, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 4'b1000};
    vecs[11] = '{enc_bl(4),           64'd0, 64'h40, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 4'b1000};
    vecs[12] = '{enc_addi(6, 30, 0),  64'd0, 64'h50, 1'b0, 1'b0, 1'b1, 64'h44, 64'd0, 4'b1000};
    vecs[13] = '{enc_br(30),          64'd0, 64'h54, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 4'b1000};
    vecs[14] = '{enc_addi(31, 0, 7),  64'd0, 64'h44, 1'b0, 1'b0, 1'b1, 64'd12, 64'd0, 4'b1000};
    vecs[15] = '{enc_addi(7, 31, 0),  64'd0, 64'h48, 1'b0, 1'b0, 1'b1, 64'd0, 64'd0, 4'b1000};
    vecs[16] = '{enc_adds(8, 2, 31),  64'd0, 64'h4C, 1'b0, 1'b0, 1'b1, 64'd2, 64'd0, 4'b0000};
    vecs[17] = '{enc_blt(2),          64'd0, 64'h50, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 4'b0000};
    vecs[18] = '{32'h0000_0000,       64'd0, 64'h54, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 4'b0000};
    vecs[19] = '{enc_b(-32),          64'd0, 64'h58, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 4'b0000};
    vecs[20] = '{enc_b(10),           64'd0, 64'hFFFF_FFFF_FFFF_FFD8, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 4'b0000};
    vecs[21] = '{32'hFFFF_FFFF,       64'd0, 64'h00, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 4'b0000};

    // Reset with a store on the bus: strobes must stay low.
    reset      = 1'b0;
    imem_instr = enc_stur(0, 31, 0);
    dmem_rdata = 64'd0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_imem_addr", imem_addr, 64'd0);
    chk("rst_dmem_we", 64'(dmem_we), 64'd0);
    chk("rst_dmem_re", 64'(dmem_re), 64'd0);
    reset = 1'b1;

    for (int k = 0; k < NV; k++) begin
      imem_instr = vecs[k].instr;
      dmem_rdata = vecs[k].rdata;
      model_step(vecs[k].instr, e_we, e_re, e_chk, e_addr, e_wdata, e_rdata);
      #1;
      chk("tbl_pc", imem_addr, vecs[k].pc);
      chk("tbl_we", 64'(dmem_we), 64'(vecs[k].we));
      chk("tbl_re", 64'(dmem_re), 64'(vecs[k].re));
      if (vecs[k].chk_addr) chk("tbl_addr", dmem_addr, vecs[k].addr);
      if (vecs[k].we) chk("tbl_wdata", dmem_wdata, vecs[k].wdata);
      @(posedge clk);
      #1;
`ifdef CPU_FLAGS_OUT_EN
      chk("tbl_flags", 64'(flags), 64'(vecs[k].nzcv));
`endif
      @(negedge clk);
    end

    // Randomized instruction stream against the model.
    for (int k = 0; k < 1500; k++) mstep(rand_instr());

    // Expose every register through the ALU result.
    for (int i = 0; i < 32; i++) mstep(enc_addi(i, i, 0));

    // Asynchronous reset mid-cycle: PC and strobes react without a clock edge.
    imem_instr = enc_ldur(1, 31, 0);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_pc", imem_addr, 64'd0);
    chk("async_rst_re", 64'(dmem_re), 64'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 32; i++) mstep(enc_addi(i, i, 0));
    mstep(enc_blt(100));
    mstep(enc_cbz(7, 16));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
